imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the decode stage.
- Accepts an instruction word plus immediate-format select, and produces the sign- or zero-extended immediate one cycle later.
- Covers all RV32I/Zicsr immediate formats, generalised to any data width.
- A 2-entry elastic buffer (output register + skid register) decouples the fetch side from the execute side without creating a combinational ready path.

---
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV32I/Zicsr immediate generator with a 2-entry elastic
// buffer (output register + skid register); extension happens before the registers.
module imm_gen_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      ins,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] imm_op,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [1:0]       busy_cnt
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_R = 3'd2;
  localparam logic [2:0] SRC_B = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;
  localparam logic [2:0] SRC_J = 3'd5;
  localparam logic [2:0] SRC_Z = 3'd6;

  // State encoding doubles as the held-item count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [WIDTH-1:0] ext_imm;
  logic             ext_err;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^ins[6:0];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    case (imm_src)
      SRC_I: ext_imm = {{(WIDTH-12){ins[31]}}, ins[31:20]};
      SRC_S: ext_imm = {{(WIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
      SRC_R: ext_imm = '0;
      SRC_B: ext_imm = {{(WIDTH-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SRC_U: ext_imm = {{(WIDTH-31){ins[31]}}, ins[30:12], 12'h000};
      SRC_J: ext_imm = {{(WIDTH-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      SRC_Z: ext_imm = {{(WIDTH-5){1'b0}}, ins[19:15]};
      default: ext_err = 1'b1;
    endcase
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic             out_err_q, out_err_d, skid_err_q, skid_err_d;

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign busy_cnt  = state_q;
  assign imm_op    = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    out_err_d  = out_err_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_err_d = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          out_imm_d = ext_imm;
          out_tag_d = in_tag;
          out_err_d = ext_err;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_valid && out_ready) begin
          out_imm_d = ext_imm;
          out_tag_d = in_tag;
          out_err_d = ext_err;
        end else if (in_valid) begin
          skid_imm_d = ext_imm;
          skid_tag_d = in_tag;
          skid_err_d = ext_err;
          state_d    = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          out_imm_d = skid_imm_q;
          out_tag_d = skid_tag_q;
          out_err_d = skid_err_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_err_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_err_q  <= out_err_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_err_q <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a queue-based model checked every cycle
// on a 32-bit and a 64-bit instance, plus directed literal expectations.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  imm_src;
  logic [31:0] ins;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic [1:0]  busy32;

  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;
  logic [1:0]  busy64;

  imm_gen_pipe #(.WIDTH(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .imm_src(imm_src), .ins(ins), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_op(imm32), .out_tag(tag32), .out_err(out_err32),
    .busy_cnt(busy32)
  );

  imm_gen_pipe #(.WIDTH(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .imm_src(imm_src), .ins(ins), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_op(imm64), .out_tag(tag64), .out_err(out_err64),
    .busy_cnt(busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
  } item_t;

  item_t exp_q[$];
  int    drain_cnt = 0;
  logic  acc_seen  = 1'b0;

  // Immediate value as a signed integer, widened by ordinary sign extension.
  function automatic logic [63:0] model_imm(input logic [2:0] src, input logic [31:0] w);
    longint v;
    case (src)
      3'd0: v = $signed(w[31:20]);
      3'd1: v = $signed({w[31:25], w[11:7]});
      3'd3: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      3'd4: v = $signed({w[31:12], 12'h000});
      3'd5: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      3'd6: v = longint'(w[19:15]);
      default: v = 0;
    endcase
    return v;
  endfunction

  // Per-cycle compare and model update, sampled late in the low clock phase.
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      exp_q.delete();
      acc_seen = 1'b0;
      check("rst_out_valid", out_valid32, 0);
      check("rst_busy", busy32, 0);
      check("rst_imm", imm32, 0);
      check("rst_in_ready", in_ready32, 1);
    end else begin
      logic acc, drn;
      check("busy_cnt", busy32, exp_q.size());
      check("busy_cnt64", busy64, exp_q.size());
      check("in_ready", in_ready32, exp_q.size() < 2);
      check("out_valid", out_valid32, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("imm_op32", imm32, {32'h0, exp_q[0].imm[31:0]});
        check("imm_op64", imm64, exp_q[0].imm);
        check("out_tag", tag32, exp_q[0].tag);
        check("out_err", out_err32, exp_q[0].err);
      end
      acc = in_valid && (exp_q.size() < 2);
      drn = out_ready && (exp_q.size() > 0);
      acc_seen = acc;
      if (drn) begin
        void'(exp_q.pop_front());
        drain_cnt++;
      end
      if (acc) exp_q.push_back('{imm: model_imm(imm_src, ins), tag: in_tag, err: (imm_src == 3'd7)});
    end
  end

  task automatic offer(input logic [2:0] src, input logic [31:0] w, input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    imm_src  = src;
    ins      = w;
    in_tag   = tag;
  endtask

  logic [2:0]  fmt_src [8] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2};
  logic [31:0] fmt_ins [8] = '{32'hFFF00093, 32'h00A12423, 32'hFE000EE3, 32'hFE000E63,
                               32'h123450B7, 32'h800000EF, 32'h0007D073, 32'hFFFFFFFF};
  logic [31:0] fmt_exp [8] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'hFFFFF7FC,
                               32'h12345000, 32'hFFF00000, 32'h0000000F, 32'h00000000};

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = 3'd0; ins = 32'h0; in_tag = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    check("init_in_ready", in_ready32, 1);
    check("init_tag", tag32, 0);
    check("init_err", out_err32, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Format sweep, one item at a time
    for (int i = 0; i < 8; i++) begin
      offer(fmt_src[i], fmt_ins[i], 5'(i + 1));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("fmt_imm", imm32, fmt_exp[i]);
      check("fmt_valid", out_valid32, 1);
    end

    // Width generalisation on the 64-bit instance
    offer(3'd0, 32'h80000013, 5'd10);
    @(negedge clk); in_valid = 1'b0; #1;
    check("w64_i", imm64, 64'hFFFFFFFFFFFFF800);
    offer(3'd1, 32'h00A12423, 5'd11);
    @(negedge clk); in_valid = 1'b0; #1;
    check("w64_s", imm64, 64'h0000000000000008);

    // Illegal format followed by R-type, back to back
    offer(3'd7, 32'hFFFFFFFF, 5'd12);
    offer(3'd2, 32'hFFFFFFFF, 5'd13);
    #1;
    check("err_imm", imm32, 0);
    check("err_flag", out_err32, 1);
    @(negedge clk); in_valid = 1'b0; #1;
    check("r_imm", imm32, 0);
    check("r_err", out_err32, 0);
    check("r_tag", tag32, 13);
    @(negedge clk);

    // Backpressure and skid ordering
    out_ready = 1'b0;
    offer(3'd0, 32'h00100093, 5'd1);
    offer(3'd0, 32'h00200093, 5'd2);
    offer(3'd0, 32'h00300093, 5'd3);
    #1;
    check("bp_busy", busy32, 2);
    check("bp_in_ready", in_ready32, 0);
    check("bp_tag_head", tag32, 1);
    repeat (2) @(negedge clk);
    #1;
    check("bp_hold_tag", tag32, 1);
    check("bp_hold_imm", imm32, 32'h1);
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_tag2", tag32, 2);
    check("bp_busy_after", busy32, 1);
    @(negedge clk); in_valid = 1'b0; #1;
    check("bp_tag3", tag32, 3);
    @(negedge clk); #1;
    check("bp_empty", busy32, 0);

    // Streaming: one accept and one drain every cycle
    base = drain_cnt;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      imm_src = 3'($urandom_range(0, 7)); ins = $urandom; in_tag = 5'($urandom);
      #1;
      if (k > 0) begin
        check("stream_busy", busy32, 1);
        check("stream_valid", out_valid32, 1);
      end
    end
    @(negedge clk); in_valid = 1'b0; #1;
    check("stream_tail_busy", busy32, 1);
    @(negedge clk); #1;
    check("stream_drained", 64'(drain_cnt - base), 100);

    // Asynchronous reset while holding two items
    out_ready = 1'b0;
    offer(3'd0, 32'hFFF00093, 5'd21);
    offer(3'd0, 32'hFFF00093, 5'd22);
    @(negedge clk); in_valid = 1'b0;
    #1;
    check("pre_rst_busy", busy32, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid32, 0);
    check("async_busy", busy32, 0);
    check("async_imm", imm32, 0);
    check("async_in_ready", in_ready32, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(3'd4, 32'h123450B7, 5'd23);
    @(negedge clk); in_valid = 1'b0; #1;
    check("post_rst_imm", imm32, 32'h12345000);
    check("post_rst_tag", tag32, 23);

    // Random traffic with random backpressure; offers stay stable until taken
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!(in_valid && !acc_seen)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        imm_src  = 3'($urandom_range(0, 7));
        ins      = $urandom;
        in_tag   = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("final_empty", busy32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
